// File: rtl/fir_ds_pkg.sv
// Shared widths, address/window typedefs and the window-length helper for
// the anti-aliasing downscaler FIR window sequencing.
package fir_ds_pkg;

  localparam int X_ROM_LEN_LOG2 = 8;
  localparam int Y_ROM_LEN_LOG2 = 8;
  localparam int MAX_X_DEC_LOG2 = 4;
  localparam int OUT_CNT_W      = 12;

  typedef logic [X_ROM_LEN_LOG2-1:0] xaddr_t;
  typedef logic [Y_ROM_LEN_LOG2-1:0] yaddr_t;
  typedef logic [MAX_X_DEC_LOG2-1:0] xwin_t;

  // Index of the last pixel in an X window; a zero-length entry acts as length 1.
  function automatic xwin_t win_last_idx(input xwin_t len);
    xwin_t one;
    one = xwin_t'(1);
    return (len == '0) ? '0 : (len - one);
  endfunction

endpackage

// File: rtl/fir_window_seq_addr_wrap.sv
// rom_addr_wrap: holds a ROM read address that walks an inclusive
// [start, end] segment and wraps back to start after end. The segment
// bounds are captured on load together with the address restart.
module rom_addr_wrap #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  input  logic         load,
  input  logic [W-1:0] start_addr,
  input  logic [W-1:0] end_addr,
  output logic [W-1:0] addr
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] start_q;
  logic [W-1:0] end_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] addr_d;

  // Next address: restart on load, otherwise step or wrap at the segment end.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = start_addr;
    end else if (advance) begin
      addr_d = (addr_q == end_q) ? start_q : (addr_q + ONE);
    end
  end

  // Segment bounds are captured only when a new configuration is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
    end else if (load) begin
      start_q <= start_addr;
      end_q   <= end_addr;
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/fir_window_seq.sv
// fir_window_seq: X/Y window-ROM address sequencer feeding FIR tap loading.
// X side counts accepted input pixels per X window (length read from the
// ROM at xw); Y side counts emitted output pixels per output line.
// Optional build macro FIR_WINDOW_SEQ_CHECK_EN adds the sticky cfg_err output.
module fir_window_seq #(
  parameter int X_ROM_LEN_LOG2 = fir_ds_pkg::X_ROM_LEN_LOG2,
  parameter int Y_ROM_LEN_LOG2 = fir_ds_pkg::Y_ROM_LEN_LOG2,
  parameter int MAX_X_DEC_LOG2 = fir_ds_pkg::MAX_X_DEC_LOG2,
  parameter int OUT_CNT_W      = fir_ds_pkg::OUT_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_load,
  input  logic [X_ROM_LEN_LOG2-1:0] x_start_addr,
  input  logic [X_ROM_LEN_LOG2-1:0] x_end_addr,
  input  logic [Y_ROM_LEN_LOG2-1:0] y_start_addr,
  input  logic [Y_ROM_LEN_LOG2-1:0] y_end_addr,
  input  logic [OUT_CNT_W-1:0]      tar_width,
  input  logic                      data_enable,
  input  logic [MAX_X_DEC_LOG2-1:0] xwin_val,
  input  logic                      en_output,
  output logic [X_ROM_LEN_LOG2-1:0] xw,
  output logic [Y_ROM_LEN_LOG2-1:0] yw,
  output logic                      x_win_last,
  output logic                      line_done
`ifdef FIR_WINDOW_SEQ_CHECK_EN
  ,
  output logic                      cfg_err
`endif
);

  import fir_ds_pkg::win_last_idx;

  localparam logic [MAX_X_DEC_LOG2-1:0] X_ONE = {{(MAX_X_DEC_LOG2-1){1'b0}}, 1'b1};
  localparam logic [OUT_CNT_W-1:0]      Y_ONE = {{(OUT_CNT_W-1){1'b0}}, 1'b1};

  logic [MAX_X_DEC_LOG2-1:0] x_cnt_q, x_cnt_d;
  logic [OUT_CNT_W-1:0]      y_cnt_q, y_cnt_d;
  logic                      x_win_last_q, x_win_last_d;
  logic                      line_done_q, line_done_d;
  logic [MAX_X_DEC_LOG2-1:0] x_last_idx;
  logic [OUT_CNT_W-1:0]      y_last_idx;
  logic                      x_done;
  logic                      y_done;

  // Window/line completion; enables are ignored while a configuration loads.
  always_comb begin
    x_last_idx = win_last_idx(xwin_val);
    y_last_idx = tar_width - Y_ONE;
    x_done     = data_enable && !cfg_load && (x_cnt_q == x_last_idx);
    y_done     = en_output && !cfg_load && (y_cnt_q == y_last_idx);
  end

  // Next-state for both pixel counters and the completion pulses.
  always_comb begin
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    x_win_last_d = x_done;
    line_done_d  = y_done;
    if (cfg_load) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else begin
      if (data_enable) begin
        x_cnt_d = x_done ? '0 : (x_cnt_q + X_ONE);
      end
      if (en_output) begin
        y_cnt_d = y_done ? '0 : (y_cnt_q + Y_ONE);
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      x_win_last_q <= 1'b0;
      line_done_q  <= 1'b0;
    end else begin
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      x_win_last_q <= x_win_last_d;
      line_done_q  <= line_done_d;
    end
  end

  rom_addr_wrap #(
    .W(X_ROM_LEN_LOG2)
  ) u_x_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (x_done),
    .load       (cfg_load),
    .start_addr (x_start_addr),
    .end_addr   (x_end_addr),
    .addr       (xw)
  );

  rom_addr_wrap #(
    .W(Y_ROM_LEN_LOG2)
  ) u_y_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (y_done),
    .load       (cfg_load),
    .start_addr (y_start_addr),
    .end_addr   (y_end_addr),
    .addr       (yw)
  );

  assign x_win_last = x_win_last_q;
  assign line_done  = line_done_q;

`ifdef FIR_WINDOW_SEQ_CHECK_EN
  logic cfg_err_q;

  // Sticky configuration error: a load re-evaluates the new bounds, and a
  // zero window length seen on an accepted pixel sets it until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else if (cfg_load) begin
      cfg_err_q <= (x_start_addr > x_end_addr) || (y_start_addr > y_end_addr) ||
                   (tar_width == '0);
    end else if (data_enable && (xwin_val == '0)) begin
      cfg_err_q <= 1'b1;
    end
  end

  assign cfg_err = cfg_err_q;
`endif

endmodule

// File: tb/tb_fir_window_seq.sv
// Directed testbench for fir_window_seq: X window walk, Y line walk,
// enable gaps, mid-window reload, asynchronous reset and (when built with
// FIR_WINDOW_SEQ_CHECK_EN) the sticky cfg_err flag.
module tb_fir_window_seq;

  import fir_ds_pkg::*;

  logic     clk;
  logic     rst_n;
  logic     cfg_load;
  xaddr_t   x_start_addr;
  xaddr_t   x_end_addr;
  yaddr_t   y_start_addr;
  yaddr_t   y_end_addr;
  logic [OUT_CNT_W-1:0] tar_width;
  logic     data_enable;
  xwin_t    xwin_val;
  logic     en_output;
  xaddr_t   xw;
  yaddr_t   yw;
  logic     x_win_last;
  logic     line_done;
`ifdef FIR_WINDOW_SEQ_CHECK_EN
  logic     cfg_err;
`endif

  xwin_t xrom [0:255];

  int testCount = 0;
  int failCount = 0;

  fir_window_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_load     (cfg_load),
    .x_start_addr (x_start_addr),
    .x_end_addr   (x_end_addr),
    .y_start_addr (y_start_addr),
    .y_end_addr   (y_end_addr),
    .tar_width    (tar_width),
    .data_enable  (data_enable),
    .xwin_val     (xwin_val),
    .en_output    (en_output),
    .xw           (xw),
    .yw           (yw),
    .x_win_last   (x_win_last),
    .line_done    (line_done)
`ifdef FIR_WINDOW_SEQ_CHECK_EN
    ,
    .cfg_err      (cfg_err)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Zero-latency window ROM model driven by the DUT address.
  always_comb begin
    xwin_val = xrom[xw];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic loadConfig(input xaddr_t xs, input xaddr_t xe, input yaddr_t ys,
                            input yaddr_t ye, input logic [OUT_CNT_W-1:0] tw);
    x_start_addr = xs;
    x_end_addr   = xe;
    y_start_addr = ys;
    y_end_addr   = ye;
    tar_width    = tw;
    cfg_load     = 1'b1;
    applyStimulus();
    cfg_load     = 1'b0;
  endtask

  // Expected X walk over ROM {3,2,4} at 0x10..0x12, one entry per edge.
  xaddr_t expXw   [9] = '{8'h10, 8'h10, 8'h11, 8'h11, 8'h12, 8'h12, 8'h12, 8'h12, 8'h10};
  logic   expXLast[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  // Expected Y walk over 0x05..0x06 with four outputs per line.
  yaddr_t expYw   [9] = '{8'h05, 8'h05, 8'h05, 8'h06, 8'h06, 8'h06, 8'h06, 8'h05, 8'h05};
  logic   expLine [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  // Gap pattern with window length 2.
  logic   gapDe   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  xaddr_t gapXw   [4] = '{8'h10, 8'h10, 8'h11, 8'h11};
  logic   gapLast [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 256; i++) xrom[i] = 4'd1;
    xrom[8'h10] = 4'd3;
    xrom[8'h11] = 4'd2;
    xrom[8'h12] = 4'd4;

    rst_n        = 1'b0;
    cfg_load     = 1'b0;
    x_start_addr = '0;
    x_end_addr   = '0;
    y_start_addr = '0;
    y_end_addr   = '0;
    tar_width    = '0;
    data_enable  = 1'b0;
    en_output    = 1'b0;

    #2;
    checkOutput("reset_xw", 32'(xw), 32'h0);
    checkOutput("reset_yw", 32'(yw), 32'h0);
    checkOutput("reset_xlast", 32'(x_win_last), 32'h0);
    checkOutput("reset_line", 32'(line_done), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load segments, enables held high during the load must be ignored.
    data_enable = 1'b1;
    en_output   = 1'b1;
    loadConfig(8'h10, 8'h12, 8'h05, 8'h06, 12'd4);
    checkOutput("load_xw", 32'(xw), 32'h10);
    checkOutput("load_yw", 32'(yw), 32'h05);
    checkOutput("load_xlast", 32'(x_win_last), 32'h0);
    en_output = 1'b0;

    // Continuous input pixels across the X segment and its wrap.
    data_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus();
      checkOutput($sformatf("xwalk_xw%0d", i), 32'(xw), 32'(expXw[i]));
      checkOutput($sformatf("xwalk_last%0d", i), 32'(x_win_last), 32'(expXLast[i]));
    end

    // Output pixels walk the Y segment, X is frozen meanwhile.
    data_enable = 1'b0;
    en_output   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus();
      checkOutput($sformatf("ywalk_yw%0d", i), 32'(yw), 32'(expYw[i]));
      checkOutput($sformatf("ywalk_line%0d", i), 32'(line_done), 32'(expLine[i]));
    end
    en_output = 1'b0;
    checkOutput("ywalk_xfrozen", 32'(xw), 32'h10);

    // Gaps in data_enable hold the count and address.
    xrom[8'h10] = 4'd2;
    for (int i = 0; i < 4; i++) begin
      data_enable = gapDe[i];
      applyStimulus();
      checkOutput($sformatf("gap_xw%0d", i), 32'(xw), 32'(gapXw[i]));
      checkOutput($sformatf("gap_last%0d", i), 32'(x_win_last), 32'(gapLast[i]));
    end

    // Reload after one pixel of a three-pixel window.
    xrom[8'h11] = 4'd3;
    data_enable = 1'b1;
    applyStimulus();
    checkOutput("mid_pre_xw", 32'(xw), 32'h11);
    en_output = 1'b1;
    loadConfig(8'h20, 8'h21, 8'h05, 8'h06, 12'd4);
    checkOutput("mid_xw", 32'(xw), 32'h20);
    checkOutput("mid_yw", 32'(yw), 32'h05);
    checkOutput("mid_xlast", 32'(x_win_last), 32'h0);
    checkOutput("mid_line", 32'(line_done), 32'h0);
    en_output   = 1'b0;
    xrom[8'h20] = 4'd2;
    applyStimulus();
    checkOutput("mid_cnt0_xw", 32'(xw), 32'h20);
    checkOutput("mid_cnt0_last", 32'(x_win_last), 32'h0);
    applyStimulus();
    checkOutput("mid_cnt1_xw", 32'(xw), 32'h21);
    checkOutput("mid_cnt1_last", 32'(x_win_last), 32'h1);

    // Asynchronous reset clears state without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_xw", 32'(xw), 32'h0);
    checkOutput("async_yw", 32'(yw), 32'h0);
    checkOutput("async_xlast", 32'(x_win_last), 32'h0);
    checkOutput("async_line", 32'(line_done), 32'h0);
    data_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef FIR_WINDOW_SEQ_CHECK_EN
    xrom[8'h30] = 4'd0;
    loadConfig(8'h30, 8'h31, 8'h05, 8'h06, 12'd4);
    checkOutput("err_clean", 32'(cfg_err), 32'h0);
    data_enable = 1'b1;
    applyStimulus();
    checkOutput("err_zero_win", 32'(cfg_err), 32'h1);
    checkOutput("err_len1_xw", 32'(xw), 32'h31);
    checkOutput("err_len1_last", 32'(x_win_last), 32'h1);
    data_enable = 1'b0;
    applyStimulus();
    checkOutput("err_sticky", 32'(cfg_err), 32'h1);
    loadConfig(8'h30, 8'h31, 8'h05, 8'h06, 12'd4);
    checkOutput("err_cleared", 32'(cfg_err), 32'h0);
    loadConfig(8'h40, 8'h3f, 8'h05, 8'h06, 12'd4);
    checkOutput("err_bad_bounds", 32'(cfg_err), 32'h1);
    loadConfig(8'h30, 8'h31, 8'h05, 8'h06, 12'd0);
    checkOutput("err_zero_width", 32'(cfg_err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
